// File: rtl/arb_rr_pry.sv
// Round-robin arbiter with a one-hot pointer, a registered grant and back-to-back grants on ack.
// Optional ARB_RR_PRY_LOCK_EN adds input lck, which holds the current grant across ack.

// Finds the lowest set bit within one group of bits.
module pry_lsb #(
  parameter int W    = 2,
  parameter int IMPL = 0
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] oht
);
  generate
    if (IMPL == 0) begin : g_arith
      assign oht = req & (~req + 1'b1);
    end else begin : g_loop
      always_comb begin
        logic found;
        oht   = '0;
        found = 1'b0;
        for (int i = 0; i < W; i++) begin
          if (req[i] && !found) begin
            oht[i] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end
  endgenerate
endmodule

// LSB-first priority to one-hot. Requests are split into groups of SPLIT bits,
// the lowest set bit is found in each group, and the lowest non-empty group is selected.
module pry2oht #(
  parameter int WIDTH          = 8,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] oht
);
  localparam int NG = (WIDTH + SPLIT - 1) / SPLIT;
  localparam int PW = NG * SPLIT;

  logic [PW-1:0]             req_p, oht_p;
  logic [NG-1:0][SPLIT-1:0]  grp_oht;
  logic [NG-1:0]             grp_any, grp_sel;

  always_comb begin
    req_p            = '0;
    req_p[WIDTH-1:0] = req;
  end

  genvar g;
  generate
    for (g = 0; g < NG; g++) begin : g_grp
      pry_lsb #(.W(SPLIT), .IMPL(IMPLEMENTATION)) u_grp (
        .req (req_p[g*SPLIT +: SPLIT]),
        .oht (grp_oht[g])
      );
      assign grp_any[g] = |req_p[g*SPLIT +: SPLIT];
    end
  endgenerate

  pry_lsb #(.W(NG), .IMPL(IMPLEMENTATION)) u_top (
    .req (grp_any),
    .oht (grp_sel)
  );

  always_comb begin
    oht_p = '0;
    for (int i = 0; i < NG; i++)
      if (grp_sel[i]) oht_p[i*SPLIT +: SPLIT] = grp_oht[i];
  end

  assign oht = oht_p[WIDTH-1:0];
endmodule

module arb_rr_pry #(
  parameter int WIDTH          = 8,
  parameter int SPLIT          = 2,
  parameter int IMPLEMENTATION = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
  input  logic                     ack,
`ifdef ARB_RR_PRY_LOCK_EN
  input  logic                     lck,
`endif
  output logic [WIDTH-1:0]         gnt,
  output logic                     vld,
  output logic [$clog2(WIDTH)-1:0] idx
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] ptr, base, above, req_m, oht_m, oht_u, cand;
  logic [IW-1:0]    idx_c;
  logic             adv;

  // While busy, gnt is the pointer the next grant will see once ack lands,
  // so the candidate is ready on the same edge.
  assign base  = (state == BUSY) ? gnt : ptr;
  assign above = ~(base | (base - 1'b1));
  assign req_m = req & above;

  pry2oht #(.WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_msk (
    .req (req_m),
    .oht (oht_m)
  );
  pry2oht #(.WIDTH(WIDTH), .SPLIT(SPLIT), .IMPLEMENTATION(IMPLEMENTATION)) u_unm (
    .req (req),
    .oht (oht_u)
  );

  assign cand = (|req_m) ? oht_m : oht_u;

  // The candidate is one-hot, so OR-ing the indices of set bits gives the binary index.
  always_comb begin
    idx_c = '0;
    for (int i = 0; i < WIDTH; i++)
      if (cand[i]) idx_c = idx_c | IW'(i);
  end

`ifdef ARB_RR_PRY_LOCK_EN
  assign adv = ack & ~lck;
`else
  assign adv = ack;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      idx   <= '0;
      ptr   <= {1'b1, {(WIDTH-1){1'b0}}};
    end else if (state == IDLE) begin
      if (|req) begin
        gnt   <= cand;
        idx   <= idx_c;
        state <= BUSY;
      end
    end else if (adv) begin
      ptr <= gnt;
      if (|req) begin
        gnt <= cand;
        idx <= idx_c;
      end else begin
        gnt   <= '0;
        idx   <= '0;
        state <= IDLE;
      end
    end
  end

  assign vld = (state == BUSY);
endmodule
